// File: rtl/rk4_pkg.sv
// Shared definitions for the RK step sequencer: state encoding and stage indices.
package rk4_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_UPDATE = 3'd3,
    S_PAUSE  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Stage indices; also used directly as the datapath operand select.
  localparam logic [1:0] K1 = 2'd0;
  localparam logic [1:0] K2 = 2'd1;
  localparam logic [1:0] K3 = 2'd2;
  localparam logic [1:0] K4 = 2'd3;

endpackage

// File: rtl/rk4_step_ctrl_edge_det.sv
// One-bit rising-edge detector with a configurable reset value for the history bit.
module edge_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic D,
  output logic RISE
);

  logic d_q;

  // History register; resetting it high masks a level already present at reset release.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) d_q <= RST_VAL;
    else        d_q <= D;
  end

  assign RISE = D & ~d_q;

endmodule

// File: rtl/rk4_step_ctrl.sv
// Step/stage sequencer for an Euler/midpoint/RK4 datapath. Issues one stage at a
// time, waits for the datapath ack, loads k, then commits x/y once per step.
module rk4_step_ctrl
  import rk4_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int STG_N = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             ABORT,
  input  logic             MODE,
  input  logic [CNT_W-1:0] N_STEPS,
  input  logic             DP_ACK,
  output logic             DP_GO,
  output logic [1:0]       STAGE,
  output logic             LD_K,
  output logic             LD_XY,
  output logic             CLR,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] STEP_CNT
);

  localparam logic [1:0] LAST_STG = 2'(STG_N - 1);

  state_t           state, state_nx;
  logic [1:0]       stage_q, stage_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic [CNT_W-1:0] n_lat, n_lat_nx;
  logic [CNT_W-1:0] cnt_inc;
  logic             start_edge;

  // START history resets high so a button held through reset cannot start a run.
  edge_det #(.RST_VAL(1'b1)) u_start_edge (
    .CLK   (CLK),
    .RST_N (RST_N),
    .D     (START),
    .RISE  (start_edge)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  // State, stage, step counter and latched step target registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      stage_q <= K1;
      cnt_q   <= '0;
      n_lat   <= '0;
    end else begin
      state   <= state_nx;
      stage_q <= stage_nx;
      cnt_q   <= cnt_nx;
      n_lat   <= n_lat_nx;
    end
  end

  // Next-state and pulse decode; ABORT overrides everything outside IDLE.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    state_nx = state;
    stage_nx = stage_q;
    cnt_nx   = cnt_q;
    n_lat_nx = n_lat;
    DP_GO    = 1'b0;
    LD_K     = 1'b0;
    LD_XY    = 1'b0;
    CLR      = 1'b0;
    DONE     = 1'b0;

    case (state)
      S_IDLE: begin
        if (start_edge) begin
          CLR      = 1'b1;
          n_lat_nx = N_STEPS;
          cnt_nx   = '0;
          stage_nx = K1;
          state_nx = (N_STEPS == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        DP_GO    = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (DP_ACK) begin
          LD_K = 1'b1;
          if (stage_q < LAST_STG) begin
            stage_nx = stage_q + 2'd1;
            state_nx = S_ISSUE;
          end else begin
            state_nx = S_UPDATE;
          end
        end
      end
      S_UPDATE: begin
        LD_XY    = 1'b1;
        stage_nx = K1;
        // Saturate at the target so the counter can never wrap.
        if (cnt_q != n_lat) cnt_nx = cnt_inc;
        if (cnt_inc == n_lat) state_nx = S_DONE;
        else if (MODE)        state_nx = S_PAUSE;
        else                  state_nx = S_ISSUE;
      end
      S_PAUSE: begin
        if (start_edge) state_nx = S_ISSUE;
      end
      S_DONE: begin
        DONE     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    if (ABORT && (state != S_IDLE)) begin
      state_nx = S_IDLE;
      stage_nx = K1;
      cnt_nx   = cnt_q;
      n_lat_nx = n_lat;
      LD_K     = 1'b0;
      LD_XY    = 1'b0;
      DONE     = 1'b0;
    end
  end

  assign BUSY     = (state != S_IDLE) && (state != S_PAUSE);
  assign STAGE    = stage_q;
  assign STEP_CNT = cnt_q;

endmodule
